// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Stage-enable controller for a 5-stage MIPS pipeline. It generates the
// per-stage register enables and NOP-insertion controls. It also resolves
// load-use hazards with a single bubble, squashes the wrong-path fetch after
// a taken branch/jump, and sequences a multi-cycle ALU op that holds execute
// for MUL_LAT cycles. A saturating counter records cycles with fetch stalled.
//
// Parameters
//   MUL_LAT   cycles a multi-cycle op occupies execute (1..15, 1 = no stall)
//   CNT_W     width of stall_cycles
//
// Ports
//   clk, reset                      rising-edge clock, async active-low reset
//   d_valid/d_rs/d_rt/d_multicycle  decode-stage hazard fields
//   e_valid/e_mem_to_reg/e_wa       execute-stage hazard fields
//   e_branch_taken                  execute resolved a taken branch/jump
//   fetch/decode/execute/memory_enable   stage register enables
//   fetch_flush                     fetch-to-decode register loads NOP
//   execute_bubble                  decode-to-execute register loads NOP
//   memory_bubble                   execute-to-memory register loads NOP
//   mul_start                       one-cycle start pulse to multi-cycle unit
//   mul_busy                        multi-cycle op in progress
//   stall_cycles                    saturating count of fetch-stalled cycles
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic             d_multicycle,
  input  logic             e_valid,
  input  logic             e_mem_to_reg,
  input  logic [4:0]       e_wa,
  input  logic             e_branch_taken,
  output logic             fetch_enable,
  output logic             decode_enable,
  output logic             execute_enable,
  output logic             memory_enable,
  output logic             fetch_flush,
  output logic             execute_bubble,
  output logic             memory_bubble,
  output logic             mul_start,
  output logic             mul_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {
    RUN = 1'b0,
    MUL = 1'b1
  } state_t;

  // Counter load value: the op spends its first execute cycle in RUN, so the
  // remaining MUL_LAT-1 cycles are spent in MUL.
  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       mul_start_nxt;
  logic       load_use;
  logic       mul_issue;

  assign load_use = e_valid & e_mem_to_reg & (e_wa != 5'd0) & d_valid &
                    ((d_rs == e_wa) | (d_rt == e_wa));

  // With MUL_LAT=1 the op completes in its single execute cycle.
  assign mul_issue = d_valid & d_multicycle & (MUL_LAT > 1);

  // NOTE: every output and next-state value gets a default before any branch,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    fetch_enable   = 1'b0;
    decode_enable  = 1'b0;
    execute_enable = 1'b0;
    memory_enable  = 1'b0;
    fetch_flush    = 1'b0;
    execute_bubble = 1'b0;
    memory_bubble  = 1'b0;
    mul_busy       = 1'b0;
    state_nxt      = state;
    cnt_nxt        = cnt;
    mul_start_nxt  = 1'b0;

    // While reset is held every control stays deasserted.
    if (reset) begin
      unique case (state)
        RUN: begin
          if (e_branch_taken) begin
            // The delay-slot instruction in decode proceeds, including a
            // multi-cycle op, which then sequences normally.
            fetch_enable   = 1'b1;
            decode_enable  = 1'b1;
            execute_enable = 1'b1;
            memory_enable  = 1'b1;
            fetch_flush    = 1'b1;
            if (mul_issue) begin
              state_nxt     = MUL;
              cnt_nxt       = MUL_CNT_INIT;
              mul_start_nxt = 1'b1;
            end
          end else if (load_use) begin
            // One bubble; the load moves on to memory, clearing the hazard.
            // A multi-cycle op in decode issues on the following cycle.
            execute_enable = 1'b1;
            execute_bubble = 1'b1;
            memory_enable  = 1'b1;
          end else begin
            fetch_enable   = 1'b1;
            decode_enable  = 1'b1;
            execute_enable = 1'b1;
            memory_enable  = 1'b1;
            if (mul_issue) begin
              state_nxt     = MUL;
              cnt_nxt       = MUL_CNT_INIT;
              mul_start_nxt = 1'b1;
            end
          end
        end

        MUL: begin
          // Execute is occupied; memory receives bubbles until the result
          // forwards in the following RUN cycle.
          memory_enable = 1'b1;
          memory_bubble = 1'b1;
          mul_busy      = 1'b1;
          if (cnt <= 4'd1) begin
            state_nxt = RUN;
            cnt_nxt   = 4'd0;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end

        default: state_nxt = RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      cnt          <= 4'd0;
      mul_start    <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mul_start <= mul_start_nxt;
      if (!fetch_enable && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl with MUL_LAT=4 and a 4-bit stall
// counter so saturation is reachable in a short run. Inputs change on the
// falling edge; outputs are sampled 1 time unit later, well away from the
// rising edge. Control outputs are packed into one vector:
//   {fetch_en, decode_en, execute_en, memory_en,
//    fetch_flush, execute_bubble, memory_bubble, mul_start, mul_busy}
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int MUL_LAT = 4;
  localparam int CNT_W   = 4;

  localparam logic [8:0] O_RESET = 9'b0000_000_00;
  localparam logic [8:0] O_RUN   = 9'b1111_000_00;
  localparam logic [8:0] O_BR    = 9'b1111_100_00;
  localparam logic [8:0] O_LU    = 9'b0011_010_00;
  localparam logic [8:0] O_MUL1  = 9'b0001_001_11;
  localparam logic [8:0] O_MULN  = 9'b0001_001_01;

  logic             clk = 1'b0;
  logic             reset;
  logic             d_valid, d_multicycle;
  logic [4:0]       d_rs, d_rt;
  logic             e_valid, e_mem_to_reg, e_branch_taken;
  logic [4:0]       e_wa;
  logic             fetch_enable, decode_enable, execute_enable, memory_enable;
  logic             fetch_flush, execute_bubble, memory_bubble;
  logic             mul_start, mul_busy;
  logic [CNT_W-1:0] stall_cycles;
  logic [8:0]       outs;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .d_valid        (d_valid),
    .d_rs           (d_rs),
    .d_rt           (d_rt),
    .d_multicycle   (d_multicycle),
    .e_valid        (e_valid),
    .e_mem_to_reg   (e_mem_to_reg),
    .e_wa           (e_wa),
    .e_branch_taken (e_branch_taken),
    .fetch_enable   (fetch_enable),
    .decode_enable  (decode_enable),
    .execute_enable (execute_enable),
    .memory_enable  (memory_enable),
    .fetch_flush    (fetch_flush),
    .execute_bubble (execute_bubble),
    .memory_bubble  (memory_bubble),
    .mul_start      (mul_start),
    .mul_busy       (mul_busy),
    .stall_cycles   (stall_cycles)
  );

  assign outs = {fetch_enable, decode_enable, execute_enable, memory_enable,
                 fetch_flush, execute_bubble, memory_bubble, mul_start, mul_busy};

  // Move to the next cycle's input window, apply inputs, let logic settle.
  task automatic step(input logic dv, input logic [4:0] rs, input logic [4:0] rt,
                      input logic mc, input logic ev, input logic ld,
                      input logic [4:0] wa, input logic bt);
    @(negedge clk);
    d_valid        = dv;
    d_rs           = rs;
    d_rt           = rt;
    d_multicycle   = mc;
    e_valid        = ev;
    e_mem_to_reg   = ld;
    e_wa           = wa;
    e_branch_taken = bt;
    #1;
  endtask

  task automatic idle();
    step(1'b1, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    // Enter MUL, then pull reset mid-op.
    do_reset();
    step(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    idle();
    if (outs !== O_MUL1) begin
      errors++; $display("FAIL pre_reset_mul outs=%b expected=%b", outs, O_MUL1);
    end
    checks++;
    reset = 1'b0;
    #1;
    if (outs !== O_RESET) begin
      errors++; $display("FAIL reset_outs outs=%b expected=%b", outs, O_RESET);
    end
    checks++;
    if (stall_cycles !== 4'd0) begin
      errors++; $display("FAIL reset_stall got=%0d expected=0", stall_cycles);
    end
    checks++;
    repeat (2) @(posedge clk);
    #1;
    if (outs !== O_RESET || stall_cycles !== 4'd0) begin
      errors++; $display("FAIL reset_held outs=%b stall=%0d expected=%b/0", outs, stall_cycles, O_RESET);
    end
    checks++;
    @(negedge clk);
    reset = 1'b1;
    idle();
    if (outs !== O_RUN) begin
      errors++; $display("FAIL reset_release outs=%b expected=%b", outs, O_RUN);
    end
    checks++;
    idle();
    if (outs !== O_RUN || stall_cycles !== 4'd0) begin
      errors++; $display("FAIL reset_no_resume outs=%b stall=%0d expected=%b/0", outs, stall_cycles, O_RUN);
    end
    checks++;
  endtask

  task automatic test_load_use();
    do_reset();
    // Load to $5 in execute, decode reads rt=$5.
    step(1'b1, 5'd9, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0);
    if (outs !== O_LU) begin
      errors++; $display("FAIL load_use_rt outs=%b expected=%b", outs, O_LU);
    end
    checks++;
    step(1'b1, 5'd9, 5'd5, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    if (outs !== O_RUN || stall_cycles !== 4'd1) begin
      errors++; $display("FAIL load_use_after outs=%b stall=%0d expected=%b/1", outs, stall_cycles, O_RUN);
    end
    checks++;
    // Load targeting $0 never stalls.
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);
    if (outs !== O_RUN) begin
      errors++; $display("FAIL load_use_r0 outs=%b expected=%b", outs, O_RUN);
    end
    checks++;
    // Match through rs.
    step(1'b1, 5'd7, 5'd3, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0);
    if (outs !== O_LU) begin
      errors++; $display("FAIL load_use_rs outs=%b expected=%b", outs, O_LU);
    end
    checks++;
    // Matching registers but decode invalid: no stall.
    step(1'b0, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0);
    if (outs !== O_RUN) begin
      errors++; $display("FAIL load_use_dinvalid outs=%b expected=%b", outs, O_RUN);
    end
    checks++;
    // Non-load writer of the same register: no stall.
    step(1'b1, 5'd7, 5'd7, 1'b0, 1'b1, 1'b0, 5'd7, 1'b0);
    if (outs !== O_RUN || stall_cycles !== 4'd2) begin
      errors++; $display("FAIL load_use_nonload outs=%b stall=%0d expected=%b/2", outs, stall_cycles, O_RUN);
    end
    checks++;
  endtask

  task automatic test_multicycle();
    do_reset();
    step(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    if (outs !== O_RUN) begin
      errors++; $display("FAIL mul_issue outs=%b expected=%b", outs, O_RUN);
    end
    checks++;
    idle();
    if (outs !== O_MUL1) begin
      errors++; $display("FAIL mul_first outs=%b expected=%b", outs, O_MUL1);
    end
    checks++;
    for (int i = 0; i < 2; i++) begin
      // Hazard inputs must be ignored while busy.
      step(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1);
      if (outs !== O_MULN) begin
        errors++; $display("FAIL mul_hold%0d outs=%b expected=%b", i, outs, O_MULN);
      end
      checks++;
    end
    idle();
    if (outs !== O_RUN || stall_cycles !== 4'd3) begin
      errors++; $display("FAIL mul_done outs=%b stall=%0d expected=%b/3", outs, stall_cycles, O_RUN);
    end
    checks++;
  endtask

  task automatic test_branch();
    do_reset();
    step(1'b1, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd4, 1'b1);
    if (outs !== O_BR) begin
      errors++; $display("FAIL branch outs=%b expected=%b", outs, O_BR);
    end
    checks++;
    idle();
    if (outs !== O_RUN || stall_cycles !== 4'd0) begin
      errors++; $display("FAIL branch_after outs=%b stall=%0d expected=%b/0", outs, stall_cycles, O_RUN);
    end
    checks++;
    // Branch with a multi-cycle op in the delay slot: flush, then MUL.
    step(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1);
    if (outs !== O_BR) begin
      errors++; $display("FAIL branch_mul outs=%b expected=%b", outs, O_BR);
    end
    checks++;
    idle();
    if (outs !== O_MUL1) begin
      errors++; $display("FAIL branch_mul_enter outs=%b expected=%b", outs, O_MUL1);
    end
    checks++;
  endtask

  task automatic test_load_use_multicycle();
    do_reset();
    step(1'b1, 5'd6, 5'd2, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);
    if (outs !== O_LU) begin
      errors++; $display("FAIL lu_mul_stall outs=%b expected=%b", outs, O_LU);
    end
    checks++;
    step(1'b1, 5'd6, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    if (outs !== O_RUN) begin
      errors++; $display("FAIL lu_mul_issue outs=%b expected=%b", outs, O_RUN);
    end
    checks++;
    idle();
    if (outs !== O_MUL1) begin
      errors++; $display("FAIL lu_mul_first outs=%b expected=%b", outs, O_MUL1);
    end
    checks++;
    repeat (2) idle();
    idle();
    if (outs !== O_RUN || stall_cycles !== 4'd4) begin
      errors++; $display("FAIL lu_mul_total outs=%b stall=%0d expected=%b/4", outs, stall_cycles, O_RUN);
    end
    checks++;
  endtask

  task automatic test_saturation();
    do_reset();
    // Five ops x 3 stalled cycles = 15 = all-ones for a 4-bit counter.
    for (int op = 0; op < 5; op++) begin
      step(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
      repeat (3) idle();
    end
    idle();
    if (stall_cycles !== 4'hF) begin
      errors++; $display("FAIL sat_reach got=%0d expected=15", stall_cycles);
    end
    checks++;
    step(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    repeat (3) begin
      idle();
      if (!mul_busy || stall_cycles !== 4'hF) begin
        errors++; $display("FAIL sat_hold busy=%b stall=%0d expected=1/15", mul_busy, stall_cycles);
      end
      checks++;
    end
    idle();
    if (outs !== O_RUN || stall_cycles !== 4'hF) begin
      errors++; $display("FAIL sat_end outs=%b stall=%0d expected=%b/15", outs, stall_cycles, O_RUN);
    end
    checks++;
  endtask

  initial begin
    reset = 1'b0;
    d_valid = 1'b0; d_rs = '0; d_rt = '0; d_multicycle = 1'b0;
    e_valid = 1'b0; e_mem_to_reg = 1'b0; e_wa = '0; e_branch_taken = 1'b0;
    test_reset();
    test_load_use();
    test_multicycle();
    test_branch();
    test_load_use_multicycle();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
